// File: rtl/parity_check_rx_pkg.sv
// ----------------------------------------------------------------------------
// parity_check_rx_pkg
// Shared definitions for the even-parity word generator and checker:
//   DATA_W_DEF        default payload width
//   PAR_IDX           bit position of the parity bit in a {parity, data} word
//   PAR_MAX_W         widest vector the shared reduce function accepts
//   even_parity_reduce  XOR-reduce; 0 = even number of ones (good word)
// ----------------------------------------------------------------------------
package parity_check_rx_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int PAR_IDX    = DATA_W_DEF;
    localparam int PAR_MAX_W  = 64;

    // Callers zero-extend narrower vectors; extra zeros do not change the XOR.
    function automatic logic even_parity_reduce(input logic [PAR_MAX_W-1:0] vec);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < PAR_MAX_W; i++) begin
            acc = acc ^ vec[i];
        end
        return acc;
    endfunction

endpackage

// File: rtl/parity_xor_tree.sv
// ----------------------------------------------------------------------------
// parity_xor_tree
// Combinational even-parity reduce over a W-bit vector (W <= PAR_MAX_W).
// Shared by the generator and the checker so both ends use one definition.
// Ports:
//   vec  in  W  vector to reduce
//   par  out 1  XOR of all bits of vec
// ----------------------------------------------------------------------------
module parity_xor_tree
    import parity_check_rx_pkg::*;
#(
    parameter int W = DATA_W_DEF + 1
) (
    input  logic [W-1:0] vec,
    output logic         par
);

    assign par = even_parity_reduce(PAR_MAX_W'(vec));

endmodule

// File: rtl/parity_check_rx.sv
// ----------------------------------------------------------------------------
// parity_check_rx
// Receive-side even-parity checker. Accepts {parity, data} words on a
// valid/ready stream, forwards the payload with a per-word error flag through
// one registered output stage, and keeps a saturating bad-word counter plus a
// sticky error flag for status readout.
// Ports:
//   clk         in   1         rising-edge clock
//   rst_n       in   1         synchronous active-low reset
//   in_word     in   DATA_W+1  {parity, data}
//   in_valid    in   1         in_word valid
//   in_ready    out  1         word can be accepted this cycle (combinational)
//   out_data    out  DATA_W    checked payload
//   out_perr    out  1         parity error flag for out_data
//   out_valid   out  1         out_data/out_perr valid
//   out_ready   in   1         downstream accepts
//   err_cnt     out  CNT_W     accepted bad words since reset/clear, saturating
//   err_sticky  out  1         set on any accepted bad word until cleared
//   err_clr     in   1         clears err_cnt/err_sticky; a same-cycle bad word wins
// ----------------------------------------------------------------------------
module parity_check_rx
    import parity_check_rx_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CNT_W    = 8,
    parameter int DROP_BAD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W:0]   in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_sticky,
    input  logic              err_clr
);

    localparam logic DROP_EN = (DROP_BAD != 0);

    logic              perr_s;
    logic              accept_s;
    logic              forward_s;
    logic              bad_accept_s;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_perr_r;
    logic [CNT_W-1:0]  err_cnt_r;
    logic [CNT_W-1:0]  err_cnt_next_s;
    logic              err_sticky_r;
    logic              err_sticky_next_s;

    parity_xor_tree #(
        .W (DATA_W + 1)
    ) u_xor_tree (
        .vec (in_word),
        .par (perr_s)
    );

    // The stage can take a word whenever it is empty or being drained.
    assign in_ready = !out_valid_r || out_ready;

    // Accept/forward decode for the current cycle.
    always_comb begin
        accept_s     = in_valid && in_ready;
        forward_s    = 1'b1;
        bad_accept_s = accept_s && perr_s;
        if (perr_s && DROP_EN) begin
            forward_s = 1'b0;
        end else begin
            forward_s = 1'b1;
        end
    end

    // Error counter and sticky flag next state; a bad word in the clear cycle
    // restarts the count at one rather than being lost.
    always_comb begin
        err_cnt_next_s    = err_cnt_r;
        err_sticky_next_s = err_sticky_r;
        if (bad_accept_s) begin
            err_sticky_next_s = 1'b1;
            if (err_clr) begin
                err_cnt_next_s = CNT_W'(1);
            end else if (err_cnt_r == {CNT_W{1'b1}}) begin
                err_cnt_next_s = err_cnt_r;
            end else begin
                err_cnt_next_s = err_cnt_r + CNT_W'(1);
            end
        end else if (err_clr) begin
            err_cnt_next_s    = {CNT_W{1'b0}};
            err_sticky_next_s = 1'b0;
        end else begin
            err_cnt_next_s    = err_cnt_r;
            err_sticky_next_s = err_sticky_r;
        end
    end

    // Output register stage; a dropped word only empties the stage when the
    // current beat is being taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_perr_r  <= 1'b0;
        end else if (accept_s && forward_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= in_word[DATA_W-1:0];
            out_perr_r  <= perr_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Error status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_r    <= {CNT_W{1'b0}};
            err_sticky_r <= 1'b0;
        end else begin
            err_cnt_r    <= err_cnt_next_s;
            err_sticky_r <= err_sticky_next_s;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_perr   = out_perr_r;
    assign err_cnt    = err_cnt_r;
    assign err_sticky = err_sticky_r;

endmodule

// File: tb/tb_parity_check_rx.sv
// ----------------------------------------------------------------------------
// tb_parity_check_rx
// Three instances: default (forward bad words, 8-bit counter), DROP_BAD = 1,
// and CNT_W = 2. One instance is active at a time; a slot-level reference
// model predicts its outputs every cycle.
// ----------------------------------------------------------------------------
module tb_parity_check_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] in_word;
    logic       in_valid;
    logic       out_ready;
    logic       err_clr;
    int         sel;

    logic iv_a, iv_b, iv_c, clr_a, clr_b, clr_c;
    logic rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c, op_a, op_b, op_c, st_a, st_b, st_c;
    logic [3:0] od_a, od_b, od_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    assign iv_a  = in_valid && (sel == 0);
    assign iv_b  = in_valid && (sel == 1);
    assign iv_c  = in_valid && (sel == 2);
    assign clr_a = err_clr && (sel == 0);
    assign clr_b = err_clr && (sel == 1);
    assign clr_c = err_clr && (sel == 2);

    parity_check_rx #(.DATA_W(4), .CNT_W(8), .DROP_BAD(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(iv_a), .in_ready(rdy_a),
        .out_data(od_a), .out_perr(op_a), .out_valid(ov_a), .out_ready(out_ready),
        .err_cnt(cnt_a), .err_sticky(st_a), .err_clr(clr_a));

    parity_check_rx #(.DATA_W(4), .CNT_W(8), .DROP_BAD(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(iv_b), .in_ready(rdy_b),
        .out_data(od_b), .out_perr(op_b), .out_valid(ov_b), .out_ready(out_ready),
        .err_cnt(cnt_b), .err_sticky(st_b), .err_clr(clr_b));

    parity_check_rx #(.DATA_W(4), .CNT_W(2), .DROP_BAD(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(iv_c), .in_ready(rdy_c),
        .out_data(od_c), .out_perr(op_c), .out_valid(ov_c), .out_ready(out_ready),
        .err_cnt(cnt_c), .err_sticky(st_c), .err_clr(clr_c));

    always #5 clk = ~clk;

    // Observed {valid, data, perr, cnt(8), sticky} of the active instance.
    logic [14:0] obs_vec;
    logic        cur_rdy;
    always_comb begin
        case (sel)
            0:       begin obs_vec = {ov_a, od_a, op_a, cnt_a, st_a};        cur_rdy = rdy_a; end
            1:       begin obs_vec = {ov_b, od_b, op_b, cnt_b, st_b};        cur_rdy = rdy_b; end
            default: begin obs_vec = {ov_c, od_c, op_c, 6'd0, cnt_c, st_c};  cur_rdy = rdy_c; end
        endcase
    end

    int checks   = 0;
    int failures = 0;

    // Reference model: one output slot plus an error tally.
    int         m_drop;
    int         m_cmax;
    logic       m_valid;
    logic [3:0] m_data;
    logic       m_perr;
    int         m_cnt;
    logic       m_sticky;
    logic [14:0] exp_vec;
    logic        exp_rdy;
    logic        obs_rdy;

    function automatic logic is_bad(input logic [4:0] w);
        return ($countones(w) % 2) == 1;
    endfunction

    function automatic logic [4:0] make_word(input logic [3:0] d, input logic bad);
        logic p;
        p = (($countones(d) % 2) == 1) ^ bad;
        return {p, d};
    endfunction

    // Apply one cycle of inputs (just after a falling edge), advance the model
    // across the rising edge, and return at the next falling edge.
    task automatic drive(input logic [4:0] w, input logic iv, input logic ordy,
                         input logic clr, input logic rst);
        logic acc, bad;
        in_word = w; in_valid = iv; out_ready = ordy; err_clr = clr; rst_n = rst;
        #1;
        obs_rdy = cur_rdy;
        exp_rdy = !m_valid || ordy;
        @(posedge clk);
        bad = is_bad(w);
        acc = iv && exp_rdy;
        if (!rst) begin
            m_valid = 1'b0; m_data = 4'd0; m_perr = 1'b0; m_cnt = 0; m_sticky = 1'b0;
        end else begin
            if (acc && !(bad && (m_drop != 0))) begin
                m_valid = 1'b1; m_data = w[3:0]; m_perr = bad;
            end else if (m_valid && ordy) begin
                m_valid = 1'b0;
            end
            if (clr) begin
                m_cnt = 0; m_sticky = 1'b0;
            end
            if (acc && bad) begin
                m_cnt = (m_cnt + 1 > m_cmax) ? m_cmax : m_cnt + 1;
                m_sticky = 1'b1;
            end
        end
        @(negedge clk);
        exp_vec = {m_valid, m_data, m_perr, 8'(m_cnt), m_sticky};
    endtask

    task automatic test_reset(input int s);
        sel    = s;
        m_drop = (s == 1) ? 1 : 0;
        m_cmax = (s == 2) ? 3 : 255;
        drive(5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs_vec !== 15'd0 || cur_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset[%0d]: got vec=%h rdy=%0b want vec=0000 rdy=1", s, obs_vec, cur_rdy);
        end
    endtask

    task automatic test_good_stream();
        logic [4:0] words [3];
        words = '{5'b0_0011, 5'b1_0111, 5'b0_0000};
        test_reset(0);
        for (int i = 0; i < 3; i++) begin
            drive(words[i], 1'b1, 1'b1, 1'b0, 1'b1);
            checks++;
            if ({obs_rdy, obs_vec} !== {exp_rdy, exp_vec} ||
                obs_vec !== {1'b1, words[i][3:0], 1'b0, 8'd0, 1'b0}) begin
                failures++;
                $display("FAIL good_stream[%0d]: got rdy=%0b vec=%h want rdy=%0b vec=%h",
                         i, obs_rdy, obs_vec, exp_rdy, exp_vec);
            end
        end
    endtask

    task automatic test_bad_forward();
        logic [4:0] words [2];
        words = '{5'b0_0111, 5'b1_0000};
        test_reset(0);
        for (int i = 0; i < 2; i++) begin
            drive(words[i], 1'b1, 1'b1, 1'b0, 1'b1);
            checks++;
            if ({obs_rdy, obs_vec} !== {exp_rdy, exp_vec} || op_a !== 1'b1 || od_a !== words[i][3:0]) begin
                failures++;
                $display("FAIL bad_forward[%0d]: got rdy=%0b vec=%h want rdy=%0b vec=%h",
                         i, obs_rdy, obs_vec, exp_rdy, exp_vec);
            end
        end
        checks++;
        if (cnt_a !== 8'd2 || st_a !== 1'b1) begin
            failures++;
            $display("FAIL bad_forward_cnt: got cnt=%0d sticky=%0b want cnt=2 sticky=1", cnt_a, st_a);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0] first_w;
        first_w = 5'b0_1001;
        test_reset(0);
        drive(first_w, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(make_word(4'($urandom_range(0, 15)), 1'b1), 1'b1, 1'b0, 1'b0, 1'b1);
            checks++;
            if ({obs_rdy, obs_vec} !== {exp_rdy, exp_vec} || obs_rdy !== 1'b0 ||
                od_a !== first_w[3:0] || cnt_a !== 8'd0) begin
                failures++;
                $display("FAIL backpressure[%0d]: got rdy=%0b vec=%h want rdy=0 vec=%h",
                         i, obs_rdy, obs_vec, exp_vec);
            end
        end
        drive(5'b0_0110, 1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({obs_rdy, obs_vec} !== {exp_rdy, exp_vec} || obs_rdy !== 1'b1 || od_a !== 4'b0110) begin
            failures++;
            $display("FAIL backpressure_release: got rdy=%0b vec=%h want rdy=1 vec=%h",
                     obs_rdy, obs_vec, exp_vec);
        end
    endtask

    task automatic test_drop_bad();
        logic [4:0] words [4];
        logic [3:0] seen [$];
        int beats;
        words = '{5'b0_0101, 5'b0_0001, 5'b1_0001, 5'b0_0000};
        beats = 0;
        test_reset(1);
        for (int i = 0; i < 4; i++) begin
            drive(words[i], (i < 3) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b1);
            checks++;
            if ({obs_rdy, obs_vec} !== {exp_rdy, exp_vec}) begin
                failures++;
                $display("FAIL drop_bad[%0d]: got rdy=%0b vec=%h want rdy=%0b vec=%h",
                         i, obs_rdy, obs_vec, exp_rdy, exp_vec);
            end
            if (ov_b === 1'b1) begin
                beats++;
                seen.push_back(od_b);
            end
        end
        checks++;
        if (beats != 2 || seen.size() != 2 || cnt_b !== 8'd1 ||
            (seen.size() == 2 && (seen[0] !== 4'b0101 || seen[1] !== 4'b0001))) begin
            failures++;
            $display("FAIL drop_bad_summary: got beats=%0d cnt=%0d want beats=2 cnt=1", beats, cnt_b);
        end
    endtask

    task automatic test_saturation_clear();
        test_reset(2);
        for (int i = 0; i < 5; i++) begin
            drive(make_word(4'($urandom_range(0, 15)), 1'b1), 1'b1, 1'b1, 1'b0, 1'b1);
            checks++;
            if ({obs_rdy, obs_vec} !== {exp_rdy, exp_vec} ||
                cnt_c !== ((i < 2) ? 2'(i + 1) : 2'd3)) begin
                failures++;
                $display("FAIL saturate[%0d]: got cnt=%0d vec=%h want vec=%h", i, cnt_c, obs_vec, exp_vec);
            end
        end
        drive(make_word(4'b1010, 1'b1), 1'b1, 1'b1, 1'b1, 1'b1);
        checks++;
        if (cnt_c !== 2'd1 || st_c !== 1'b1 || obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL clear_with_bad: got cnt=%0d sticky=%0b want cnt=1 sticky=1", cnt_c, st_c);
        end
        drive(5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (cnt_c !== 2'd0 || st_c !== 1'b0 || obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL clear_alone: got cnt=%0d sticky=%0b want cnt=0 sticky=0", cnt_c, st_c);
        end
    endtask

    task automatic test_reset_mid();
        test_reset(0);
        drive(5'b1_0100, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(5'b0_0111, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(5'b0_0011, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs_vec !== 15'd0 || cur_rdy !== 1'b1 || obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL reset_mid: got vec=%h rdy=%0b want vec=0000 rdy=1", obs_vec, cur_rdy);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            test_reset(s);
            for (int n = 0; n < 300; n++) begin
                drive(5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), 1'b1);
                checks++;
                if ({obs_rdy, obs_vec} !== {exp_rdy, exp_vec}) begin
                    failures++;
                    $display("FAIL random[%0d,%0d]: got rdy=%0b vec=%h want rdy=%0b vec=%h",
                             s, n, obs_rdy, obs_vec, exp_rdy, exp_vec);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_word = 5'd0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; sel = 0;
        m_drop = 0; m_cmax = 255;
        m_valid = 1'b0; m_data = 4'd0; m_perr = 1'b0; m_cnt = 0; m_sticky = 1'b0;
        @(negedge clk);
        test_reset(0);
        test_good_stream();
        test_bad_forward();
        test_backpressure();
        test_drop_bad();
        test_saturation_clear();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parity_check_rx.md
Name: parity_check_rx

Overview:
- Receive-side counterpart of the team's even-parity word generator.
- Accepts {parity, data} words on a valid/ready stream and recomputes even parity.
- Forwards the data with a per-word error flag through one registered output stage.
- Keeps a saturating bad-word counter and a sticky error flag for status/CSR readout.
- Sits between the link/word source and the downstream data consumer.

Parameters:
- DATA_W, 4, payload width; input word is DATA_W+1 bits.
- CNT_W, 8, width of the bad-word counter (saturates).
- DROP_BAD, 0, 1 = discard words with parity error instead of forwarding them.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst_n  input  1  synchronous active-low reset.
- in_word  input  DATA_W+1  bit [DATA_W] = parity, bits [DATA_W-1:0] = data.
- in_valid  input  1  in_word valid.
- in_ready  output  1  block can accept in_word this cycle.
- out_data  output  DATA_W  checked payload.
- out_perr  output  1  parity error flag for out_data.
- out_valid  output  1  out_data/out_perr valid.
- out_ready  input  1  downstream accepts.
- err_cnt  output  CNT_W  number of bad words accepted since reset/clear, saturating at all-ones.
- err_sticky  output  1  set on any bad word, held until cleared.
- err_clr  input  1  one-cycle pulse; clears err_cnt and err_sticky.

Behaviour:
- Reset: clk and rst_n are the only clock and reset, as already decided.
  - When rst_n = 0 at a rising edge, reset takes effect on that edge.
  - Reset values: out_valid = 0, out_data = 0, out_perr = 0, err_cnt = 0, err_sticky = 0.
  - in_ready is combinational and therefore reads 1 after reset.
- Reset mid-transfer: any word held in the output register is lost. No partial state survives.
- Parity check:
  - perr = XOR-reduce of all DATA_W+1 bits of in_word; 1 means error (even parity).
  - Example for DATA_W = 4: in_word = 5'b0_0011 is good; 5'b0_0111 is bad.
- Handshake and datapath:
  - Single output register stage. in_ready = !out_valid || out_ready, purely combinational.
  - Accept = in_valid && in_ready. Latency is one cycle from accept to out_valid.
  - On accept with a good word, or a bad word with DROP_BAD = 0: out_data <= in_word[DATA_W-1:0], out_perr <= perr, out_valid <= 1.
  - On accept with a bad word and DROP_BAD = 1: the word is consumed but not forwarded. out_valid <= 0 if the current output is being taken (out_ready), else it is unchanged.
  - When out_valid && out_ready and there is no accept: out_valid <= 0.
  - out_data/out_perr hold stable while out_valid && !out_ready.
- Full throughput: one word per cycle when out_ready is held high. No bubbles.
- Error counting:
  - Applies to accepted bad words only; unaccepted in_valid words are never counted.
  - err_cnt <= err_cnt + 1 per accepted bad word; it holds at 2^CNT_W-1 (saturation, no wrap).
  - err_sticky <= 1 on any accepted bad word.
- Simultaneous err_clr and accepted bad word: the new error wins. Result is err_cnt = 1 and err_sticky = 1.
- err_clr alone: err_cnt = 0 and err_sticky = 0 on the next cycle.
- err_clr has no effect on the data path.

Decomposition:
- Shared package holds:
  - DATA_W default constant.
  - Parity-bit index constant (DATA_W).
  - Even-parity reduce function, shared with the generator so both ends use one definition.
- Sub-module parity_xor_tree (combinational reduce, parameter W): natural and reusable by generator and checker.
- Counter and sticky logic stay inline.

Test Plan:
- Reset, then stream good words with DATA_W = 4 and out_ready = 1.
  - Stimulus: in_word 5'b0_0011, then 5'b1_0111, then 5'b0_0000 on back-to-back cycles.
  - Required: out_data 0011/0111/0000 one cycle later, out_perr = 0, err_cnt = 0, no bubbles.
- Bad words with DROP_BAD = 0.
  - Stimulus: 5'b0_0111 then 5'b1_0000.
  - Required: both forwarded with out_perr = 1; err_cnt = 2; err_sticky = 1.
- Backpressure.
  - Stimulus: out_ready = 0 for 3 cycles with in_valid = 1.
  - Required: first word held stable on out_data; in_ready = 0; later words not consumed and not counted.
  - On out_ready = 1, the next word is accepted in the same cycle.
- DROP_BAD = 1.
  - Stimulus: good 5'b0_0101, bad 5'b0_0001, good 5'b1_0001.
  - Required: out shows only 0101 and 0001(good), with no extra out_valid beat; err_cnt = 1.
- Saturation and clear with CNT_W = 2.
  - Stimulus: 5 bad words, then err_clr asserted in the same cycle as a 6th bad word.
  - Required: err_cnt sticks at 3 after the 3rd bad word; after the clear cycle err_cnt = 1 and err_sticky = 1.
  - Then err_clr alone gives 0/0.
- Reset mid-operation.
  - Stimulus: rst_n = 0 while out_valid = 1 and out_ready = 0.
  - Required: next cycle out_valid = 0, err_cnt = 0, err_sticky = 0, in_ready = 1.
